// File: rtl/ahb_burst_master.sv
// AHB-Lite burst master: descriptor-driven INCR bursts on a read and a write channel,
// each FIFO-buffered, arbitrated round-robin per burst. Optional error abort: AHB_MASTER_ERR_EN.
module ahb_burst_master #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned BURST_LEN  = 4,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              rd_start,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [15:0]       rd_len,
  output logic              rd_busy,
  output logic              rd_done,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  input  logic              wr_start,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [15:0]       wr_len,
  output logic              wr_busy,
  output logic              wr_done,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [ADDR_W-1:0] haddr,
  output logic [1:0]        htrans,
  output logic              hwrite,
  output logic [2:0]        hsize,
  output logic [2:0]        hburst,
  output logic [DATA_W-1:0] hwdata,
  input  logic [DATA_W-1:0] hrdata,
  input  logic              hready,
  input  logic              hresp
`ifdef AHB_MASTER_ERR_EN
  ,
  output logic              bus_err
`endif
);

  localparam int unsigned Bytes = DATA_W / 8;
  localparam int unsigned Size  = $clog2(Bytes);
  localparam int unsigned LenW  = $clog2(BURST_LEN) + 1;
  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned OccW  = PtrW + 1;
  localparam logic [OccW-1:0] Depth    = OccW'(FIFO_DEPTH);
  localparam logic [15:0]     MaxBurst = 16'(BURST_LEN);

  typedef enum logic [1:0] {StIdle, StAddr, StSeq, StLast} state_e;

  // Beats in the next burst: capped by BURST_LEN, remaining beats and the 1 KB line.
  function automatic logic [LenW-1:0] calc_len(input logic [9:0] a, input logic [15:0] rem);
    logic [10:0] to_bound;
    logic [15:0] n;
    to_bound = (11'd1024 - {1'b0, a}) >> Size;
    n = MaxBurst;
    if (rem < n) n = rem;
    if ({5'd0, to_bound} < n) n = {5'd0, to_bound};
    return LenW'(n);
  endfunction

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LenW-1:0]   beats_q, beats_d;
  logic              ch_q, ch_d;
  logic [2:0]        hburst_q, hburst_d;
  logic              prio_q, prio_d;

  logic              rd_busy_q, rd_busy_d, rd_done_q, rd_done_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [15:0]       rd_rem_q, rd_rem_d;
  logic              wr_busy_q, wr_busy_d, wr_done_q, wr_done_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [15:0]       wr_rem_q, wr_rem_d;
  logic              bus_err_q, bus_err_d;

  logic [DATA_W-1:0] rmem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] wmem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   rwp_q, rrp_q, wwp_q, wrp_q;
  logic [OccW-1:0]   rcnt_q, rcnt_d, rresv_q, rresv_d, wcnt_q, wcnt_d;

  logic            data_phase, beat_done, last_beat, err;
  logic            rd_push, rd_pop, wr_push, wr_pop;
  logic [LenW-1:0] rd_blen, wr_blen, sel_blen;
  logic [OccW-1:0] rd_free, wr_avail;
  logic            rd_elig, wr_elig, launch, gnt_rd, gnt_wr, acc_start;

  assign data_phase = (state_q == StSeq) || (state_q == StLast);
`ifdef AHB_MASTER_ERR_EN
  assign err     = hresp & data_phase;
  assign bus_err = bus_err_q;
`else
  logic unused_hresp;
  assign unused_hresp = hresp;
  assign err          = 1'b0;
`endif
  assign beat_done = hready & data_phase & ~err;
  assign last_beat = hready & (state_q == StLast) & ~err;

  assign rd_push  = beat_done & ~ch_q;
  assign wr_pop   = beat_done & ch_q;
  assign rd_valid = (rcnt_q != '0);
  assign rd_pop   = rd_valid & rd_ready;
  assign wr_ready = (wcnt_q != Depth);
  assign wr_push  = wr_valid & wr_ready;

  // In-flight read beats stay reserved so the FIFO can never overflow mid-burst.
  assign rd_blen  = calc_len(rd_addr_q[9:0], rd_rem_q);
  assign wr_blen  = calc_len(wr_addr_q[9:0], wr_rem_q);
  assign rd_free  = Depth - rcnt_q - rresv_q;
  assign wr_avail = wcnt_q - OccW'(wr_pop);
  assign rd_elig  = rd_busy_q && (rd_rem_q != 16'd0) && (rd_free >= OccW'(rd_blen));
  assign wr_elig  = wr_busy_q && (wr_rem_q != 16'd0) && (wr_avail >= OccW'(wr_blen));

  assign launch   = ~err & ((state_q == StIdle) || ((state_q == StLast) && hready));
  assign gnt_rd   = launch & rd_elig & (~wr_elig | ~prio_q);
  assign gnt_wr   = launch & wr_elig & ~gnt_rd;
  assign sel_blen = gnt_wr ? wr_blen : rd_blen;
  assign acc_start = (rd_start & ~rd_busy_q) | (wr_start & ~wr_busy_q);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    beats_d  = beats_q;
    ch_d     = ch_q;
    hburst_d = hburst_q;
    prio_d   = prio_q;
    unique case (state_q)
      StIdle, StLast: begin
        if (gnt_rd || gnt_wr) begin
          state_d  = StAddr;
          ch_d     = gnt_wr;
          addr_d   = gnt_wr ? wr_addr_q : rd_addr_q;
          beats_d  = sel_blen - LenW'(1);
          hburst_d = (sel_blen == LenW'(1)) ? 3'b000 : 3'b001;
          prio_d   = gnt_rd;
        end else if ((state_q == StLast) && hready) begin
          state_d = StIdle;
        end
      end
      StAddr, StSeq: begin
        if (hready) begin
          if (beats_q == '0) begin
            state_d = StLast;
          end else begin
            state_d = StSeq;
            addr_d  = addr_q + ADDR_W'(Bytes);
            beats_d = beats_q - LenW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (err) state_d = StIdle;
  end

  always_comb begin
    rd_busy_d = rd_busy_q;
    rd_done_d = 1'b0;
    rd_addr_d = rd_addr_q;
    rd_rem_d  = rd_rem_q;
    wr_busy_d = wr_busy_q;
    wr_done_d = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_rem_d  = wr_rem_q;
    bus_err_d = bus_err_q;
    rresv_d   = rresv_q + (gnt_rd ? OccW'(rd_blen) : '0) - OccW'(rd_push);
    rcnt_d    = rcnt_q + OccW'(rd_push) - OccW'(rd_pop);
    wcnt_d    = wcnt_q + OccW'(wr_push) - OccW'(wr_pop);

    if (gnt_rd) begin
      rd_addr_d = rd_addr_q + (ADDR_W'(rd_blen) << Size);
      rd_rem_d  = rd_rem_q - 16'(rd_blen);
    end
    if (gnt_wr) begin
      wr_addr_d = wr_addr_q + (ADDR_W'(wr_blen) << Size);
      wr_rem_d  = wr_rem_q - 16'(wr_blen);
    end
    if (last_beat && !ch_q && (rd_rem_q == 16'd0)) begin
      rd_busy_d = 1'b0;
      rd_done_d = 1'b1;
    end
    if (last_beat && ch_q && (wr_rem_q == 16'd0)) begin
      wr_busy_d = 1'b0;
      wr_done_d = 1'b1;
    end
    // A bus error drops the rest of the active descriptor; the other channel is untouched.
    if (err) begin
      bus_err_d = 1'b1;
      if (ch_q) begin
        wr_busy_d = 1'b0;
        wr_rem_d  = 16'd0;
        wr_done_d = 1'b1;
      end else begin
        rd_busy_d = 1'b0;
        rd_rem_d  = 16'd0;
        rd_done_d = 1'b1;
        rresv_d   = '0;
      end
    end else if (acc_start) begin
      bus_err_d = 1'b0;
    end
    if (rd_start && !rd_busy_q) begin
      if (rd_len == 16'd0) begin
        rd_done_d = 1'b1;
      end else begin
        rd_busy_d = 1'b1;
        rd_addr_d = rd_addr;
        rd_rem_d  = rd_len;
      end
    end
    if (wr_start && !wr_busy_q) begin
      if (wr_len == 16'd0) begin
        wr_done_d = 1'b1;
      end else begin
        wr_busy_d = 1'b1;
        wr_addr_d = wr_addr;
        wr_rem_d  = wr_len;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      beats_q   <= '0;
      ch_q      <= 1'b0;
      hburst_q  <= 3'b000;
      prio_q    <= 1'b0;
      rd_busy_q <= 1'b0;
      rd_done_q <= 1'b0;
      rd_addr_q <= '0;
      rd_rem_q  <= 16'd0;
      wr_busy_q <= 1'b0;
      wr_done_q <= 1'b0;
      wr_addr_q <= '0;
      wr_rem_q  <= 16'd0;
      bus_err_q <= 1'b0;
      rcnt_q    <= '0;
      rresv_q   <= '0;
      wcnt_q    <= '0;
      rwp_q     <= '0;
      rrp_q     <= '0;
      wwp_q     <= '0;
      wrp_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      beats_q   <= beats_d;
      ch_q      <= ch_d;
      hburst_q  <= hburst_d;
      prio_q    <= prio_d;
      rd_busy_q <= rd_busy_d;
      rd_done_q <= rd_done_d;
      rd_addr_q <= rd_addr_d;
      rd_rem_q  <= rd_rem_d;
      wr_busy_q <= wr_busy_d;
      wr_done_q <= wr_done_d;
      wr_addr_q <= wr_addr_d;
      wr_rem_q  <= wr_rem_d;
      bus_err_q <= bus_err_d;
      rcnt_q    <= rcnt_d;
      rresv_q   <= rresv_d;
      wcnt_q    <= wcnt_d;
      if (rd_push) rwp_q <= rwp_q + PtrW'(1);
      if (rd_pop)  rrp_q <= rrp_q + PtrW'(1);
      if (wr_push) wwp_q <= wwp_q + PtrW'(1);
      if (wr_pop)  wrp_q <= wrp_q + PtrW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rd_push) rmem_q[rwp_q] <= hrdata;
  end

  always_ff @(posedge clk) begin
    if (wr_push) wmem_q[wwp_q] <= wr_data;
  end

  always_comb begin
    unique case (state_q)
      StAddr:  htrans = 2'b10;
      StSeq:   htrans = 2'b11;
      default: htrans = 2'b00;
    endcase
  end

  assign haddr   = addr_q;
  assign hwrite  = ch_q;
  assign hburst  = hburst_q;
  assign hsize   = 3'(Size);
  // The write head stays put until its data phase completes, so hwdata holds across wait states.
  assign hwdata  = (ch_q && data_phase) ? wmem_q[wrp_q] : '0;
  assign rd_data = rmem_q[rrp_q];
  assign rd_busy = rd_busy_q;
  assign rd_done = rd_done_q;
  assign wr_busy = wr_busy_q;
  assign wr_done = wr_done_q;

endmodule

// File: tb/tb_ahb_burst_master.sv
// Scoreboard bench for ahb_burst_master: directed descriptors against a zero/wait-state slave model.
module tb_ahb_burst_master;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        rd_start, rd_busy, rd_done, rd_valid, rd_ready;
  logic [31:0] rd_addr, rd_data;
  logic [15:0] rd_len;
  logic        wr_start, wr_busy, wr_done, wr_valid, wr_ready;
  logic [31:0] wr_addr, wr_data;
  logic [15:0] wr_len;
  logic [31:0] haddr, hwdata, hrdata;
  logic [1:0]  htrans;
  logic        hwrite, hready, hresp;
  logic [2:0]  hsize, hburst;
`ifdef AHB_MASTER_ERR_EN
  logic        bus_err;
`endif

  ahb_burst_master #(
    .DATA_W(32), .ADDR_W(32), .BURST_LEN(4), .FIFO_DEPTH(8)
  ) dut (
    .clk(clk), .n_rst(n_rst),
    .rd_start(rd_start), .rd_addr(rd_addr), .rd_len(rd_len), .rd_busy(rd_busy),
    .rd_done(rd_done), .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .wr_start(wr_start), .wr_addr(wr_addr), .wr_len(wr_len), .wr_busy(wr_busy),
    .wr_done(wr_done), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
    .hwdata(hwdata), .hrdata(hrdata), .hready(hready), .hresp(hresp)
`ifdef AHB_MASTER_ERR_EN
    , .bus_err(bus_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  burst;
  } bus_t;

  bus_t        bus_exp[$];
  logic [31:0] rd_exp[$];
  logic [31:0] wd_exp[$];
  int checks = 0, failures = 0;
  int rd_done_cnt = 0, wr_done_cnt = 0, bus_beats = 0;
  bit mon_en = 1'b1;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  // Slave model: captures the accepted address phase and answers in the data phase.
  logic        s_dp_valid, s_dp_write;
  logic [31:0] s_dp_addr;
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      s_dp_valid <= 1'b0;
      s_dp_write <= 1'b0;
      s_dp_addr  <= 32'h0;
    end else if (hready) begin
      s_dp_valid <= htrans[1];
      s_dp_write <= hwrite;
      s_dp_addr  <= haddr;
    end
  end
  assign hrdata = (s_dp_valid && hready) ? mem_f(s_dp_addr) : 32'hDEAD_BEEF;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_burst(input logic [31:0] a, input int beats, input logic wr);
    bus_t e;
    for (int i = 0; i < beats; i++) begin
      e.addr  = a + 32'(4 * i);
      e.trans = (i == 0) ? 2'b10 : 2'b11;
      e.wr    = wr;
      e.burst = (beats == 1) ? 3'b000 : 3'b001;
      bus_exp.push_back(e);
    end
  endtask

  task automatic expect_read(input logic [31:0] a, input int len);
    for (int i = 0; i < len; i++) rd_exp.push_back(mem_f(a + 32'(4 * i)));
  endtask

  task automatic push_word(input logic [31:0] w);
    wr_data  = w;
    wr_valid = 1'b1;
    wd_exp.push_back(w);
    @(posedge clk); #1;
    wr_valid = 1'b0;
  endtask

  task automatic start_rd(input logic [31:0] a, input logic [15:0] len);
    rd_addr = a; rd_len = len; rd_start = 1'b1;
    @(posedge clk); #1;
    rd_start = 1'b0;
  endtask

  task automatic start_wr(input logic [31:0] a, input logic [15:0] len);
    wr_addr = a; wr_len = len; wr_start = 1'b1;
    @(posedge clk); #1;
    wr_start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (!rd_busy && !wr_busy && htrans == 2'b00 && bus_exp.size() == 0 &&
          rd_exp.size() == 0 && wd_exp.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, "_idle"}, 64'(ok), 64'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted transfer / popped word is compared against the scoreboard head.
  initial forever begin
    bus_t e;
    @(negedge clk);
    if (n_rst && mon_en) begin
      if (htrans[1] && hready) begin
        bus_beats++;
        if (bus_exp.size() == 0) begin
          checks++; failures++;
          $display("FAIL bus_unexpected: got haddr=0x%0h htrans=%b, none expected", haddr, htrans);
        end else begin
          e = bus_exp.pop_front();
          check("bus_haddr", 64'(haddr), 64'(e.addr));
          check("bus_htrans", 64'(htrans), 64'(e.trans));
          check("bus_hwrite", 64'(hwrite), 64'(e.wr));
          check("bus_hburst", 64'(hburst), 64'(e.burst));
        end
      end
      if (rd_valid && rd_ready) begin
        if (rd_exp.size() == 0) begin
          checks++; failures++;
          $display("FAIL rd_unexpected: got 0x%0h, none expected", rd_data);
        end else check("rd_data", 64'(rd_data), 64'(rd_exp.pop_front()));
      end
      if (s_dp_valid && s_dp_write && hready) begin
        if (wd_exp.size() == 0) begin
          checks++; failures++;
          $display("FAIL wd_unexpected: got 0x%0h, none expected", hwdata);
        end else check("hwdata", 64'(hwdata), 64'(wd_exp.pop_front()));
      end
      if (rd_done) begin
        rd_done_cnt++;
        check("rd_done_busy", 64'(rd_busy), 64'd0);
      end
      if (wr_done) begin
        wr_done_cnt++;
        check("wr_done_busy", 64'(wr_busy), 64'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, d1, b0;
    logic [31:0] held_addr;
    bit found;
    n_rst = 1'b0; rd_start = 1'b0; wr_start = 1'b0; rd_addr = 32'h0; wr_addr = 32'h0;
    rd_len = 16'd0; wr_len = 16'd0; rd_ready = 1'b1; wr_valid = 1'b0; wr_data = 32'h0;
    hready = 1'b1; hresp = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_htrans", 64'(htrans), 64'd0);
    check("rst_hwrite", 64'(hwrite), 64'd0);
    check("rst_haddr", 64'(haddr), 64'd0);
    check("rst_hwdata", 64'(hwdata), 64'd0);
    check("rst_hburst", 64'(hburst), 64'd0);
    check("rst_hsize", 64'(hsize), 64'd2);
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_wr_ready", 64'(wr_ready), 64'd1);
    check("rst_busy", 64'({rd_busy, wr_busy}), 64'd0);
    check("rst_done", 64'({rd_done, wr_done}), 64'd0);
    n_rst = 1'b1;
    @(posedge clk); #1;

    // Two 4-beat read bursts, words in order
    d0 = rd_done_cnt;
    expect_read(32'h100, 8);
    push_burst(32'h100, 4, 1'b0);
    push_burst(32'h110, 4, 1'b0);
    start_rd(32'h100, 16'd8);
    check("t1_busy_next", 64'(rd_busy), 64'd1);
    check("t1_no_early_nonseq", 64'(htrans), 64'd0);
    wait_idle("t1", 200);
    check("t1_rd_done_cnt", 64'(rd_done_cnt - d0), 64'd1);

    // Write split at the 1 KB line
    d0 = wr_done_cnt;
    for (int i = 0; i < 4; i++) push_word(32'hC0DE_0000 + 32'(i));
    push_burst(32'h3F8, 2, 1'b1);
    push_burst(32'h400, 2, 1'b1);
    start_wr(32'h3F8, 16'd4);
    wait_idle("t2", 200);
    check("t2_wr_done_cnt", 64'(wr_done_cnt - d0), 64'd1);

    // Three wait states mid-read-burst
    expect_read(32'h200, 4);
    push_burst(32'h200, 4, 1'b0);
    start_rd(32'h200, 16'd4);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (haddr == 32'h208 && htrans == 2'b11) begin
        found = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check("t3_found_beat2", 64'(found), 64'd1);
    hready = 1'b0;
    held_addr = haddr;
    for (int k = 0; k < 3; k++) begin
      check("t3_haddr_held", 64'(haddr), 64'h208);
      check("t3_htrans_held", 64'(htrans), 64'd3);
      @(posedge clk); #1;
    end
    check("t3_haddr_after", 64'(haddr), 64'(held_addr));
    hready = 1'b1;
    wait_idle("t3", 200);

    // Zero-length, ignored restart, and 1-beat SINGLE bursts around the 1 KB line
    d0 = rd_done_cnt;
    b0 = bus_beats;
    start_rd(32'h0, 16'd0);
    check("t6_len0_done", 64'(rd_done), 64'd1);
    check("t6_len0_busy", 64'(rd_busy), 64'd0);
    @(posedge clk); #1;
    check("t6_len0_done_low", 64'(rd_done), 64'd0);
    check("t6_len0_no_bus", 64'(bus_beats - b0), 64'd0);
    expect_read(32'h900, 4);
    push_burst(32'h900, 4, 1'b0);
    start_rd(32'h900, 16'd4);
    start_rd(32'hA00, 16'd4);
    wait_idle("t6_ignore", 200);
    expect_read(32'h3FC, 2);
    push_burst(32'h3FC, 1, 1'b0);
    push_burst(32'h400, 1, 1'b0);
    start_rd(32'h3FC, 16'd2);
    wait_idle("t6_single", 200);
    check("t6_rd_done_cnt", 64'(rd_done_cnt - d0), 64'd3);

    // Asynchronous reset in the middle of a burst
    mon_en = 1'b0;
    start_rd(32'hC00, 16'd8);
    repeat (3) @(posedge clk);
    #3;
    n_rst = 1'b0;
    #1;
    check("rstmid_htrans", 64'(htrans), 64'd0);
    check("rstmid_haddr", 64'(haddr), 64'd0);
    check("rstmid_busy", 64'(rd_busy), 64'd0);
    check("rstmid_rd_valid", 64'(rd_valid), 64'd0);
    @(posedge clk); #1;
    n_rst = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Simultaneous starts alternate R,W,R,W with read first after reset
    d0 = rd_done_cnt;
    d1 = wr_done_cnt;
    for (int i = 0; i < 8; i++) push_word(32'h5A00_0000 + 32'(i * 3));
    check("t4_wr_full", 64'(wr_ready), 64'd0);
    expect_read(32'h500, 8);
    push_burst(32'h500, 4, 1'b0);
    push_burst(32'h600, 4, 1'b1);
    push_burst(32'h510, 4, 1'b0);
    push_burst(32'h610, 4, 1'b1);
    rd_addr = 32'h500; rd_len = 16'd8; wr_addr = 32'h600; wr_len = 16'd8;
    rd_start = 1'b1; wr_start = 1'b1;
    @(posedge clk); #1;
    rd_start = 1'b0; wr_start = 1'b0;
    wait_idle("t4", 300);
    check("t4_rd_done_cnt", 64'(rd_done_cnt - d0), 64'd1);
    check("t4_wr_done_cnt", 64'(wr_done_cnt - d1), 64'd1);

    // Back-pressure: only FIFO_DEPTH beats issue until the consumer pops
    rd_ready = 1'b0;
    expect_read(32'h800, 16);
    for (int i = 0; i < 4; i++) push_burst(32'h800 + 32'(16 * i), 4, 1'b0);
    b0 = bus_beats;
    start_rd(32'h800, 16'd16);
    repeat (30) @(posedge clk);
    #1;
    check("t5_beats_issued", 64'(bus_beats - b0), 64'd8);
    check("t5_htrans_idle", 64'(htrans), 64'd0);
    check("t5_still_busy", 64'(rd_busy), 64'd1);
    rd_ready = 1'b1;
    wait_idle("t5", 400);
    check("t5_beats_total", 64'(bus_beats - b0), 64'd16);

`ifdef AHB_MASTER_ERR_EN
    // Error response on the second beat aborts the read; a later write start clears bus_err
    mon_en = 1'b0;
    d0 = rd_done_cnt;
    start_rd(32'h1000, 16'd8);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (haddr == 32'h1008 && htrans == 2'b11) begin
        found = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check("err_found_beat2", 64'(found), 64'd1);
    hresp = 1'b1;
    @(posedge clk); #1;
    hresp = 1'b0;
    check("err_htrans_idle", 64'(htrans), 64'd0);
    check("err_rd_done", 64'(rd_done), 64'd1);
    check("err_rd_busy", 64'(rd_busy), 64'd0);
    check("err_bus_err", 64'(bus_err), 64'd1);
    repeat (10) @(posedge clk);
    #1;
    check("err_no_restart", 64'(htrans), 64'd0);
    rd_exp.delete();
    bus_exp.delete();
    mon_en = 1'b1;
    push_word(32'hE770_0001);
    push_burst(32'h40, 1, 1'b1);
    start_wr(32'h40, 16'd1);
    check("err_cleared", 64'(bus_err), 64'd0);
    wait_idle("err_wr", 100);
`endif

    check("end_bus_q", 64'(bus_exp.size()), 64'd0);
    check("end_rd_q", 64'(rd_exp.size()), 64'd0);
    check("end_wd_q", 64'(wd_exp.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ahb_burst_master.md
# ahb_burst_master

Parametrised AHB-Lite bus master for the edge-detection datapath. It replaces single-beat pixel reads and writes with descriptor-driven incrementing bursts on one read channel and one write channel. Each channel is buffered by its own FIFO, and the two channels are arbitrated round-robin per burst. It sits between the pixel buffers (greyscale in, edge result out) and the system AHB-Lite fabric.

## Interface
Parameters:
- DATA_W, 32: bus and pixel-word width; one of 8/16/32/64.
- ADDR_W, 32: address width.
- BURST_LEN, 4: maximum beats per burst; power of two, 2..16.
- FIFO_DEPTH, 8: entries per channel FIFO; power of two, at least BURST_LEN.

Ports:
- clk, in, 1: single clock; all logic on the rising edge.
- n_rst, in, 1: asynchronous active-low reset.
- rd_start, in, 1: load read descriptor; accepted only when rd_busy=0.
- rd_addr, in, ADDR_W: read start byte address, aligned to DATA_W/8.
- rd_len, in, 16: read length in beats.
- rd_busy, out, 1: read descriptor active.
- rd_done, out, 1: one-cycle pulse when the last read word has been pushed into the FIFO.
- rd_data, out, DATA_W: read FIFO head word.
- rd_valid, out, 1: read FIFO is not empty.
- rd_ready, in, 1: consumer pop.
- wr_start, wr_addr, wr_len, wr_busy, wr_done: write-channel equivalents. wr_done pulses when the data phase of the last write beat completes.
- wr_data, in, DATA_W: producer word.
- wr_valid, in, 1: producer push.
- wr_ready, out, 1: write FIFO is not full.
- haddr, out, ADDR_W: AHB address.
- htrans, out, 2: IDLE=00, NONSEQ=10, SEQ=11.
- hwrite, out, 1: AHB write.
- hsize, out, 3: constant log2(DATA_W/8).
- hburst, out, 3: INCR=001, or SINGLE=000 for a 1-beat burst.
- hwdata, out, DATA_W: AHB write data.
- hrdata, in, DATA_W: AHB read data.
- hready, in, 1: AHB transfer done.
- hresp, in, 1: AHB error response.
- bus_err, out, 1: sticky error flag; exists only with AHB_MASTER_ERR_EN.

## Operation
- Each descriptor is split into bursts. Burst length is min(BURST_LEN, remaining beats, beats left to the next 1 KB boundary).
- Read channel is eligible when remaining > 0 and free FIFO space ≥ that burst length. Space counts entries already reserved by in-flight beats.
- Write channel is eligible when remaining > 0 and FIFO occupancy ≥ that burst length.
- Arbiter: round-robin per burst. Read has priority first after reset. A burst is never preempted.
- State machine:
  - IDLE: wait for an eligible channel.
  - ADDR: NONSEQ on the bus.
  - SEQ: remaining beats.
  - LAST: data phase of the final beat, htrans=IDLE.
  - After LAST, go to ADDR if the other (or same) channel is eligible, otherwise IDLE.
- Pipelining: the address phase of beat n+1 overlaps the data phase of beat n. While hready=0, haddr, htrans, hwrite and hwdata are held.
- Addresses increment by DATA_W/8 per beat. The 16-bit beat counter has no wrap.
- rd_len=0 or wr_len=0: done pulses the cycle after start. No bus traffic; busy never asserts.
- rd_start while rd_busy=1 is ignored. Same for the write channel.
- Simultaneous push and pop on a full or empty FIFO:
  - Read side: a pop on full and a push from hrdata in the same cycle are both accepted.
  - Write side: a push on full is refused via wr_ready=0.
- Reset values:
  - htrans=00, hwrite=0, haddr=0, hwdata=0, hburst=000.
  - rd_valid=0, wr_ready=1, busy=0, done=0, bus_err=0.
  - FIFOs empty, arbiter priority = read.
- Reset mid-burst aborts immediately. Outputs return to reset values asynchronously.

## Timing
- rd_start or wr_start at edge t: busy=1 from t+1; first NONSEQ drives the bus from t+2 at the earliest.
- Read data: sampled at the data-phase edge where hready=1, written to the FIFO on that edge, rd_valid visible the next cycle.
- Write data: the FIFO word is presented on hwdata for the whole data phase. It is popped on the edge where hready=1.
- Zero-wait bus: a BURST_LEN burst takes BURST_LEN+1 cycles from NONSEQ to data-phase end. Back-to-back bursts have no idle cycle.
- Done pulse: exactly 1 cycle, asserted the cycle after the final qualifying edge. busy deasserts in that same cycle.

## Configuration
- AHB_MASTER_ERR_EN defined:
  - hresp=1 in a data phase forces htrans=IDLE on the next cycle and drops the rest of the active descriptor.
  - The active channel pulses done and clears busy.
  - bus_err is set. It clears on the next accepted start of either channel.
  - The other channel continues normally.
- AHB_MASTER_ERR_EN undefined: hresp is ignored, bus_err is absent, and bursts always run to completion.

## Test plan
- Read rd_addr=0x100, rd_len=8, BURST_LEN=4, zero-wait, rd_ready=1: two INCR bursts at 0x100 and 0x110. htrans sequence 10,11,11,11 then 10,11,11,11. 8 words out in order; rd_done pulses once.
- Write wr_addr=0x3F8, wr_len=4, DATA_W=32, FIFO preloaded with 4 words: bursts split at the 1 KB line. First burst 2 beats at 0x3F8 and 0x3FC; second NONSEQ at 0x400; wr_done pulses after beat 4.
- hready=0 for 3 cycles mid-read-burst: haddr and htrans held constant; no FIFO push; words still arrive in order.
- rd_start and wr_start on the same edge, both len=8: bursts alternate R,W,R,W; read goes first.
- rd_ready=0 with FIFO_DEPTH=8, rd_len=16: exactly 8 beats issued, then htrans=IDLE. Bursts resume after pops.
- With AHB_MASTER_ERR_EN, hresp=1 on beat 2 of an 8-beat read: IDLE on the next cycle; rd_done pulses; bus_err=1; a later wr_start clears bus_err.
